// File: rtl/seven_segment_scan_ctrl_pkg.sv
// rtl/seven_segment_scan_ctrl_pkg.sv - shared types, segment table and hex decode for the scan controller
// Purpose: scan state type, 7-bit {A,B,C,D,E,F,G} glyph constants, nibble decode.
// Ports: none (package).
package seven_segment_scan_ctrl_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // {A,B,C,D,E,F,G}, 1 = segment lit
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seven_segment_scan_ctrl_if.sv
// rtl/seven_segment_scan_ctrl_if.sv - value producer handshake bundle for the scan controller
// Purpose: carries the displayed value offer from producer (master) to controller (slave).
// Signals:
//   value_i     4*DIGITS  nibble k = digit k, digit 0 least significant
//   dp_i        DIGITS    decimal point per digit
//   value_valid 1         producer offers value_i/dp_i
//   value_ready 1         controller pending register empty
interface seven_segment_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value_i;
  logic [DIGITS-1:0]   dp_i;
  logic                value_valid;
  logic                value_ready;

  modport master (
    output value_i,
    output dp_i,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_i,
    input  dp_i,
    input  value_valid,
    output value_ready
  );
endinterface

// File: rtl/seven_segment_scan_ctrl_decoder.sv
// rtl/seven_segment_scan_ctrl_decoder.sv - nibble to pin-level segment pattern with blanking and polarity
// Purpose: decodes the currently scanned nibble, applies glyph blanking and pin polarity.
// Ports:
//   nibble    in  4  muxed shadow nibble of the scanned digit
//   dp        in  1  decimal point of the scanned digit
//   glyph_off in  1  suppress A..G (leading zero), DP still shown
//   drive     in  1  0 during the blanking gap: everything off
//   seg       out 8  {A,B,C,D,E,F,G,DP} at pin polarity (combinational)
module seven_segment_scan_ctrl_decoder
  import seven_segment_scan_ctrl_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       glyph_off,
  input  logic       drive,
  output logic [7:0] seg
);

  logic [7:0] seg_raw;

  always_comb begin
    seg_raw = 8'h00;
    if (drive) begin
      seg_raw = {(glyph_off ? 7'h00 : seg_decode(nibble)), dp};
    end
    seg = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// rtl/seven_segment_scan_ctrl.sv - time-multiplexed seven-segment scan controller
// Purpose: scans DIGITS nibbles onto one segment bus with a blanking gap before each
//   digit, leading-zero suppression, and frame-atomic update via a pending register.
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous active-high reset
//   val_if     slave          value_i/dp_i/value_valid in, value_ready out
//   lz_en      in   1         leading-zero suppression enable (sampled live)
//   seg        out  8         {A,B,C,D,E,F,G,DP}, registered, polarity per ACTIVE_LOW
//   digit_en   out  DIGITS    one-hot digit select, registered, polarity per ACTIVE_LOW
//   frame_tick out  1         registered one-cycle pulse per frame boundary
module seven_segment_scan_ctrl
  import seven_segment_scan_ctrl_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  seven_segment_scan_ctrl_if.slave val_if,
  input  logic                     lz_en,
  output logic [7:0]               seg,
  output logic [DIGITS-1:0]        digit_en,
  output logic                     frame_tick
);

  localparam int TIMER_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int TW        = $clog2(TIMER_MAX);
  localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0]     SCAN_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0]     BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF    = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] EN_OFF     = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  scan_state_t         state, state_next;
  logic [TW-1:0]       timer, timer_next;
  logic [IW-1:0]       idx, idx_next;
  logic                boundary;

  logic [4*DIGITS-1:0] shadow_value, pending_value;
  logic [DIGITS-1:0]   shadow_dp, pending_dp;
  logic                pending_full;
  logic                accept;

  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic                glyph_off;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   en_raw, digit_en_next;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      timer <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      idx   <= idx_next;
    end
  end

  // ---------------- FSM: next state ----------------
  // boundary marks the last DRIVE cycle of the last digit; the shadow swap
  // and frame_tick both key off this cycle.
  always_comb begin
    state_next = state;
    timer_next = timer + TW'(1);
    idx_next   = idx;
    boundary   = 1'b0;
    case (state)
      BLANK: begin
        if (timer == BLANK_LAST) begin
          state_next = DRIVE;
          timer_next = '0;
        end
      end
      DRIVE: begin
        if (timer == SCAN_LAST) begin
          state_next = BLANK;
          timer_next = '0;
          if (idx == IDX_LAST) begin
            idx_next = '0;
            boundary = 1'b1;
          end else begin
            idx_next = idx + IW'(1);
          end
        end
      end
      default: begin
        state_next = BLANK;
        timer_next = '0;
      end
    endcase
  end

  // ---------------- FSM: outputs (registered below) ----------------
  assign cur_nibble = shadow_value[{idx, 2'b00} +: 4];
  assign cur_dp     = shadow_dp[idx];

  // A digit's glyph is a leading zero when it and every higher nibble are 0
  // and no higher digit carries a DP; its own DP still shows, so "0.07"-style
  // values keep their point.
  always_comb begin
    glyph_off = lz_en && (idx != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx) && shadow_value[4*k +: 4] != 4'h0) begin
        glyph_off = 1'b0;
      end
      if (k > int'(idx) && shadow_dp[k]) begin
        glyph_off = 1'b0;
      end
    end
  end

  always_comb begin
    en_raw = '0;
    if (state == DRIVE) begin
      en_raw[idx] = 1'b1;
    end
    digit_en_next = (ACTIVE_LOW != 0) ? ~en_raw : en_raw;
  end

  seven_segment_scan_ctrl_decoder #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_seven_segment (
    .nibble    (cur_nibble),
    .dp        (cur_dp),
    .glyph_off (glyph_off),
    .drive     (state == DRIVE),
    .seg       (seg_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF;
      digit_en   <= EN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_next;
      digit_en   <= digit_en_next;
      frame_tick <= boundary;
    end
  end

  // ---------------- pending / shadow registers ----------------
  // accept and a boundary swap are mutually exclusive (accept needs an empty
  // pending register), so a value accepted on the boundary cycle waits one frame.
  assign accept = val_if.value_valid && val_if.value_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_value       <= '0;
      shadow_dp          <= '0;
      pending_value      <= '0;
      pending_dp         <= '0;
      pending_full       <= 1'b0;
      val_if.value_ready <= 1'b0;
    end else if (boundary && pending_full) begin
      shadow_value       <= pending_value;
      shadow_dp          <= pending_dp;
      pending_full       <= 1'b0;
      val_if.value_ready <= 1'b1;
    end else if (accept) begin
      pending_value      <= val_if.value_i;
      pending_dp         <= val_if.dp_i;
      pending_full       <= 1'b1;
      val_if.value_ready <= 1'b0;
    end else begin
      val_if.value_ready <= !pending_full;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb/tb_seven_segment_scan_ctrl.sv - self-checking bench for seven_segment_scan_ctrl
module tb_seven_segment_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int SCAN   = 8;
  localparam int BLANK  = 2;
  localparam int SLOT   = BLANK + SCAN;
  localparam int FRAME  = DIGITS * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lz_en = 1'b0;
  logic [7:0] seg;
  logic [3:0] digit_en;
  logic       frame_tick;

  seven_segment_scan_ctrl_if #(.DIGITS(DIGITS)) val_if ();

  seven_segment_scan_ctrl #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN),
    .BLANK_CYC  (BLANK),
    .ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .val_if     (val_if),
    .lz_en      (lz_en),
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Standard hex glyphs, {A,B,C,D,E,F,G}
  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
  } offer_t;

  offer_t      offers[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          k;
  logic [15:0] sh_v, pend_v;
  logic [3:0]  sh_dp, pend_dp;
  bit          m_full, m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp,
                                         input bit lz, input int d);
    logic [3:0] nib;
    bit         off;
    nib = v[4*d +: 4];
    off = lz && (d > 0) && ((v >> (4*d)) == 16'h0) && ((dp >> (d + 1)) == 4'h0);
    return {(off ? 7'h00 : glyph[nib]), dp[d]};
  endfunction

  task automatic drive_inputs();
    if (offers.size() > 0) begin
      val_if.value_valid = 1'b1;
      val_if.value_i     = offers[0].v;
      val_if.dp_i        = offers[0].dp;
    end else begin
      val_if.value_valid = 1'b0;
      val_if.value_i     = 16'($urandom);
      val_if.dp_i        = 4'($urandom);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    sh_v    = '0;
    sh_dp   = '0;
    pend_v  = '0;
    pend_dp = '0;
    m_full  = 1'b0;
    m_ready = 1'b0;
    offers.delete();
  endtask

  task automatic check_reset_pins();
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_digit_en", 32'(digit_en), 32'h0);
    check("rst_ready", 32'(val_if.value_ready), 32'h0);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
  endtask

  // One clock: pins after edge k reflect frame position k-1 and the shadow
  // that was live before that edge; boundary edges are multiples of FRAME.
  task automatic cycle();
    int         p, d, r;
    logic [7:0] e_seg;
    logic [3:0] e_en;
    bit         e_tick, accept;
    @(negedge clk);
    k++;
    p = (k - 1) % FRAME;
    d = p / SLOT;
    r = p % SLOT;
    if (r < BLANK) begin
      e_seg = 8'h00;
      e_en  = 4'h0;
    end else begin
      e_seg = exp_seg(sh_v, sh_dp, lz_en, d);
      e_en  = 4'(1 << d);
    end
    e_tick = (k % FRAME) == 0;
    accept = val_if.value_valid && m_ready;
    if (e_tick && m_full) begin
      sh_v   = pend_v;
      sh_dp  = pend_dp;
      m_full = 1'b0;
    end else if (accept) begin
      pend_v  = val_if.value_i;
      pend_dp = val_if.dp_i;
      m_full  = 1'b1;
      void'(offers.pop_front());
    end
    m_ready = !m_full;
    check("seg", 32'(seg), 32'(e_seg));
    check("digit_en", 32'(digit_en), 32'(e_en));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("value_ready", 32'(val_if.value_ready), 32'(m_ready));
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic sync_to(input int pos);
    for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) cycle();
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] dp);
    offer_t o;
    o.v  = v;
    o.dp = dp;
    offers.push_back(o);
    drive_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog k=%0d got=timeout exp=finish", k);
    $fatal(1, "watchdog");
  end

  initial begin
    val_if.value_valid = 1'b0;
    val_if.value_i     = '0;
    val_if.dp_i        = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_pins();
    rst = 1'b0;
    drive_inputs();

    // scan order with 0x1234
    run(5);
    push(16'h1234, 4'h0);
    run(90);

    // mid-frame update stays atomic
    sync_to(15);
    push(16'h5678, 4'h0);
    run(100);

    // accept on the frame_tick cycle
    sync_to(0);
    push(16'h00AB, 4'h0);
    run(90);

    // back-pressure: three queued values
    for (int i = 0; i < 3; i++) push(16'($urandom), 4'($urandom));
    run(170);

    // leading zeros
    lz_en = 1'b1;
    push(16'h0007, 4'h0);
    run(90);
    push(16'h0000, 4'h0);
    run(90);
    push(16'h0007, 4'b0100);
    run(90);

    // asynchronous reset in the middle of a DRIVE slot
    push(16'hBEEF, 4'h1);
    sync_to(15);
    #2 rst = 1'b1;
    #1 check_reset_pins();
    @(negedge clk);
    check_reset_pins();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_inputs();
    run(50);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      lz_en = 1'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        push(16'($urandom) >> $urandom_range(0, 15),
             ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
      end
      run($urandom_range(1, 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
